// File: rtl/redirect_pkg.sv
// Shared types and constants for the branch/exception redirect arbiter.
package redirect_pkg;

  localparam int PC_W       = 32;
  localparam int DEF_LANES  = 2;
  localparam int DEF_STAGES = 2;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic            mistaken;
    logic            taken;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc;
  } resolve_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_PEND = 1'b1
  } rd_state_t;

  // Index width that stays legal when the count is 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/redirect_prio_enc.sv
// Picks the oldest mistaken lane in the oldest (highest-index) stage; one-hot grant plus indices.
module redirect_prio_enc import redirect_pkg::*; #(
  parameter int STAGES = DEF_STAGES,
  parameter int LANES  = DEF_LANES,
  parameter int SW     = idx_w(STAGES),
  parameter int LW     = idx_w(LANES)
) (
  input  logic [STAGES*LANES-1:0] req,
  output logic                    valid,
  output logic [SW-1:0]           stage,
  output logic [LW-1:0]           lane,
  output logic [STAGES*LANES-1:0] grant
);

  logic [STAGES-1:0]    stage_any;
  logic [STAGES*LW-1:0] lane_flat;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [LANES-1:0] lreq;
      logic [LW-1:0]    sel;

      assign lreq = req[gi*LANES +: LANES];
      assign stage_any[gi] = |lreq;

      // Descending scan so the lowest set lane is the final assignment.
      always_comb begin
        sel = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
          if (lreq[l]) sel = LW'(l);
        end
      end

      assign lane_flat[gi*LW +: LW] = sel;
    end
  endgenerate

  always_comb begin
    valid = 1'b0;
    stage = '0;
    lane  = '0;
    for (int s = 0; s < STAGES; s++) begin
      if (stage_any[s]) begin
        valid = 1'b1;
        stage = SW'(s);
        lane  = lane_flat[s*LW +: LW];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (valid) grant[int'(stage) * LANES + int'(lane)] = 1'b1;
  end

endmodule

// File: rtl/redirect_arbiter.sv
// Arbitrates exception and branch-mispredict redirects into a single registered fetch redirect.
// Optional per-stage mispredict counters are built when REDIRECT_PERF_EN is defined.
module redirect_arbiter import redirect_pkg::*; #(
  parameter int LANES  = DEF_LANES,
  parameter int STAGES = DEF_STAGES
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  resolve_t [STAGES*LANES-1:0]      res_i,
  input  logic                             exc_valid_i,
  input  logic [PC_W-1:0]                  exc_target_i,
  output logic                             redirect_valid_o,
  input  logic                             redirect_ready_i,
  output logic [PC_W-1:0]                  redirect_pc_o,
  output logic [STAGES:0]                  flush_o,
  output logic [STAGES-1:0][31:0]          perf_cnt_o
);

  localparam int N  = STAGES * LANES;
  localparam int SW = idx_w(STAGES);
  localparam int LW = idx_w(LANES);

  logic [N-1:0]  mis_req;
  logic          enc_valid;
  logic [SW-1:0] enc_stage;
  logic [LW-1:0] enc_lane;
  logic [N-1:0]  enc_grant;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_req
      assign mis_req[gi] = res_i[gi].mistaken;
    end
  endgenerate

  redirect_prio_enc #(
    .STAGES (STAGES),
    .LANES  (LANES),
    .SW     (SW),
    .LW     (LW)
  ) u_prio_enc (
    .req   (mis_req),
    .valid (enc_valid),
    .stage (enc_stage),
    .lane  (enc_lane),
    .grant (enc_grant)
  );

  resolve_t        win_res;
  logic            winner;
  logic [PC_W-1:0] win_pc;

  // AND-OR mux of the granted lane; grant is one-hot so no priority chain is needed.
  always_comb begin
    win_res = '0;
    for (int i = 0; i < N; i++) begin
      if (enc_grant[i]) win_res = win_res | res_i[i];
    end
  end

  assign winner = exc_valid_i | enc_valid;

  always_comb begin
    win_pc = '0;
    if (exc_valid_i)       win_pc = exc_target_i;
    else if (win_res.taken) win_pc = win_res.target;
    else                    win_pc = win_res.pc + PC_STEP;
  end

  rd_state_t       state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= RD_IDLE;
      pc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // A fresh winner always overwrites, even when fetch accepts the old PC this cycle.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    if (winner) begin
      state_next = RD_PEND;
      pc_next    = win_pc;
    end else if (state_reg == RD_PEND && redirect_ready_i) begin
      state_next = RD_IDLE;
    end
  end

  assign redirect_valid_o = (state_reg == RD_PEND);
  assign redirect_pc_o    = pc_reg;

  // Stage s winner flushes the instruction buffer and every register up to s+1.
  always_comb begin
    flush_o = '0;
    if (!resetn) begin
      flush_o = '0;
    end else if (exc_valid_i) begin
      flush_o = '1;
    end else if (enc_valid) begin
      for (int k = 0; k <= STAGES; k++) begin
        flush_o[k] = (k <= int'(enc_stage) + 1);
      end
    end else begin
      flush_o[0] = redirect_valid_o & ~redirect_ready_i;
    end
  end

`ifdef REDIRECT_PERF_EN
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_perf
      logic [31:0] cnt_reg;
      logic        hit;

      assign hit = enc_valid & ~exc_valid_i & (int'(enc_stage) == gi);

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                     cnt_reg <= '0;
        else if (hit && cnt_reg != '1)   cnt_reg <= cnt_reg + 32'd1;
      end

      assign perf_cnt_o[gi] = cnt_reg;
    end
  endgenerate
`else
  assign perf_cnt_o = '0;
`endif

endmodule

// File: doc/redirect_arbiter.md
REDIRECT_ARBITER -- requirements
Module: redirect_arbiter

Interface
REQ-001 Parameter LANES, default 2, issue lanes per resolving stage; lane 0 is oldest in program order.
REQ-002 Parameter STAGES, default 2, resolving stages; index 0 is youngest (decode), STAGES-1 is oldest (execute).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  clock.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 res_i  in  STAGES*LANES x resolve_t  per-lane resolution: mistaken, taken, target[31:0], pc[31:0].
REQ-007 exc_valid_i  in  1  exception/ertn redirect request.
REQ-008 exc_target_i  in  32  exception redirect PC.
REQ-009 redirect_valid_o  out  1  registered redirect request to fetch.
REQ-010 redirect_ready_i  in  1  fetch accepts redirect.
REQ-011 redirect_pc_o  out  32  registered redirect PC.
REQ-012 flush_o  out  STAGES+1  bit 0 = instruction buffer; bit k+1 = pipeline register after resolving stage k.
REQ-013 perf_cnt_o  out  STAGES x 32  per-stage mispredict counts (REDIRECT_PERF_EN only).

Function
REQ-014 Priority, combinational per cycle: exc_valid_i > highest stage index with any mistaken lane > lower stage; within a stage, lowest lane wins.
REQ-015 Winning resolution target: taken ? target : pc + 4, modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-016 Exception winner: flush_o all ones, same cycle.
REQ-017 Stage-s winner: flush_o[0..s+1] asserted same cycle, remaining bits deasserted.
REQ-018 No winner: flush_o = 0, except flush_o[0] held high while a redirect is pending (redirect_valid_o=1 and redirect_ready_i=0).
REQ-019 Any winner in cycle N SHALL load the redirect register; redirect_valid_o=1 with redirect_pc_o=winning PC in cycle N+1 (latency 1).
REQ-020 States: IDLE (valid=0), PEND (valid=1); IDLE->PEND on winner; PEND->IDLE on redirect_ready_i with no winner; PEND->PEND with PC overwritten on a new winner (overwrite takes precedence over handshake completion in the same cycle).
REQ-021 A winner coinciding with redirect_ready_i in PEND: old PC consumed, new PC presented next cycle, valid stays 1.
REQ-022 Mistaken inputs in flushed stages are ignored only in later cycles by upstream invalidation; this block applies no additional masking.

Reset
REQ-023 On resetn low, immediately: state IDLE, redirect_valid_o=0, redirect_pc_o=0, flush_o=0, all perf counters 0.
REQ-024 Reset asserted mid-PEND SHALL discard the pending redirect; first cycle after release is IDLE.

Configuration
REQ-025 Macro REDIRECT_PERF_EN defined: one 32-bit counter per stage, +1 per cycle that stage is the winner (exception not counted), saturating at 0xFFFFFFFF.
REQ-026 Macro undefined: no counter flops; perf_cnt_o tied to 0.

Structure
REQ-027 Package redirect_pkg: resolve_t struct, PC width 32, default LANES/STAGES, PC_STEP=4.
REQ-028 Sub-module redirect_prio_enc: one-hot priority picker over STAGES*LANES mistaken bits, returning a valid flag plus stage and lane indices.

Verification
REQ-029 Stage1 lane1 mistaken, taken=1, target 0x1C000100 -> flush_o=3'b111 same cycle; cycle+1 valid=1, pc=0x1C000100.
REQ-030 Stage0 lane0 (taken=0, pc 0x1C000040) and stage1 lane1 (taken=0, pc 0x1C000020) together -> stage1 wins; flush_o=3'b111, pc=0x1C000024.
REQ-031 Pending redirect with ready=0 for 3 cycles -> valid and pc stable, flush_o[0]=1 each cycle; ready=1 -> valid=0 next cycle.
REQ-032 exc_valid_i with target 0x1C008000 together with stage1 mistake -> flush_o all ones, pc=0x1C008000.
REQ-033 Stage0 not-taken at pc 0xFFFFFFFC -> redirect_pc_o=0x00000000.
REQ-034 REDIRECT_PERF_EN with counter preset near 0xFFFFFFFF, two stage1 wins -> saturates at 0xFFFFFFFF; resetn pulse mid-PEND -> valid=0, counters=0.
